// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, round constants, FSM state.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package aes_pkg;

  // AES-128 uses ten expansion rounds.
  localparam int NR = 10;

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_t;

  // Round constant for round idx (1..10), already placed in byte [31:24].
  function automatic logic [31:0] rcon_word(input logic [3:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: byte substitution by table lookup.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input byte.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign dout = SBOX[din];

endmodule

// File: rtl/key_expand_seq.sv
// AES-128 key expansion, one round key per accepted handshake; optional RK_BUFFER_EN keeps all 11 keys.
// Latency: round key 0 one cycle after KEY_IN is taken; one new key per cycle while RK_READY is high.
// Backpressure: RK_READY low freezes RK_OUT/RK_IDX; KEY_READY is high only while idle.
module key_expand_seq
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] KEY_IN,
  input  logic         KEY_VALID,
  output logic         KEY_READY,
  output logic [127:0] RK_OUT,
  output logic [3:0]   RK_IDX,
  output logic         RK_VALID,
  input  logic         RK_READY,
  output logic         DONE,
  input  logic [3:0]   RD_IDX,
  output logic [127:0] RD_KEY
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t         state_q, state_d;
  logic [127:0]   rk_out_q;
  logic [3:0]     rk_idx_q;
  logic           rk_vld_q;
  logic           done_q;
  logic           key_acc;
  logic           rk_hs;
  logic           rk_last;
  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    rot_w3, sub_w3, t_word;
  logic [31:0]    n0, n1, n2, n3;
  logic [127:0]   next_key;

  assign key_acc = KEY_VALID && (state_q == IDLE);
  assign rk_hs   = rk_vld_q && RK_READY;
  assign rk_last = (rk_idx_q == LAST_IDX);

  // Next round key from the current one: SubWord(RotWord(w3)) ^ Rcon, then the XOR chain.
  assign {w0, w1, w2, w3} = rk_out_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sub
    aes_sbox u_sbox (
      .din  (rot_w3[8*b +: 8]),
      .dout (sub_w3[8*b +: 8])
    );
  end

  assign t_word   = sub_w3 ^ rcon_word(rk_idx_q + 4'd1);
  assign n0       = w0 ^ t_word;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: start on key acceptance, return to idle after the last key is consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (key_acc) state_d = EXPAND;
      EXPAND:  if (rk_hs && rk_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: a key is only taken while idle.
  always_comb begin
    KEY_READY = (state_q == IDLE);
  end

  // Round-key register, index, valid and the end-of-expansion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_out_q <= '0;
      rk_idx_q <= '0;
      rk_vld_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (key_acc) begin
        rk_out_q <= KEY_IN;
        rk_idx_q <= '0;
        rk_vld_q <= 1'b1;
      end else if (rk_hs) begin
        if (rk_last) begin
          rk_vld_q <= 1'b0;
          done_q   <= 1'b1;
        end else begin
          rk_out_q <= next_key;
          rk_idx_q <= rk_idx_q + 4'd1;
        end
      end
    end
  end

  assign RK_OUT   = rk_out_q;
  assign RK_IDX   = rk_idx_q;
  assign RK_VALID = rk_vld_q;
  assign DONE     = done_q;

`ifdef RK_BUFFER_EN
  logic [127:0] rk_buf_q [11];

  // Mirror every RK_OUT load into the slot of the index it is loaded with.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) rk_buf_q[i] <= '0;
    end else if (key_acc) begin
      rk_buf_q[0] <= KEY_IN;
    end else if (rk_hs && !rk_last) begin
      rk_buf_q[rk_idx_q + 4'd1] <= next_key;
    end
  end

  assign RD_KEY = (RD_IDX <= LAST_IDX) ? rk_buf_q[RD_IDX] : '0;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^RD_IDX;
  assign RD_KEY        = '0;
`endif

endmodule
